// File: rtl/rename_stage_if.sv
// rtl/rename_stage_if.sv - decode/free-list/commit/dispatch signal bundle for rename_stage
interface rename_stage_if #(
    parameter int WIDTH     = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHY_REGS  = 64
);
    localparam int AREG_W = $clog2(ARCH_REGS);
    localparam int PREG_W = $clog2(PHY_REGS);
    localparam int CNT_W  = $clog2(PHY_REGS) + 1;
    localparam int POP_W  = $clog2(WIDTH) + 1;

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_uses_rs1;
    logic [WIDTH-1:0]          in_uses_rs2;
    logic [WIDTH-1:0]          in_dst_valid;
    logic [WIDTH*AREG_W-1:0]   in_rs1;
    logic [WIDTH*AREG_W-1:0]   in_rs2;
    logic [WIDTH*AREG_W-1:0]   in_rd;
    logic [CNT_W-1:0]          fl_count;
    logic [WIDTH*PREG_W-1:0]   fl_preg;
    logic [POP_W-1:0]          fl_pop;
    logic [WIDTH-1:0]          commit_valid;
    logic [WIDTH*AREG_W-1:0]   commit_rd;
    logic [WIDTH*PREG_W-1:0]   commit_preg;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_dst_valid;
    logic [WIDTH*PREG_W-1:0]   out_psrc1;
    logic [WIDTH*PREG_W-1:0]   out_psrc2;
    logic [WIDTH*PREG_W-1:0]   out_pdst;
    logic [WIDTH*PREG_W-1:0]   out_pdst_old;
    logic [WIDTH-1:0]          out_waw;

    modport slave (
        input  flush, in_valid, in_uses_rs1, in_uses_rs2, in_dst_valid,
               in_rs1, in_rs2, in_rd, fl_count, fl_preg,
               commit_valid, commit_rd, commit_preg, out_ready,
        output in_ready, fl_pop, out_valid, out_dst_valid,
               out_psrc1, out_psrc2, out_pdst, out_pdst_old, out_waw
    );

    modport master (
        output flush, in_valid, in_uses_rs1, in_uses_rs2, in_dst_valid,
               in_rs1, in_rs2, in_rd, fl_count, fl_preg,
               commit_valid, commit_rd, commit_preg, out_ready,
        input  in_ready, fl_pop, out_valid, out_dst_valid,
               out_psrc1, out_psrc2, out_pdst, out_pdst_old, out_waw
    );
endinterface

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - N-wide register rename stage with speculative and committed RATs
// Optional feature macro: RENAME_X0_ZERO_EN (x0 hardwired to p0, never renamed)
module rename_stage #(
    parameter int WIDTH     = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHY_REGS  = 64
) (
    input logic           clk,
    input logic           reset,
    rename_stage_if.slave bus
);
    localparam int AREG_W = $clog2(ARCH_REGS);
    localparam int PREG_W = $clog2(PHY_REGS);
    localparam int CNT_W  = $clog2(PHY_REGS) + 1;
    localparam int POP_W  = $clog2(WIDTH) + 1;

    logic [PREG_W-1:0]       srat      [ARCH_REGS];
    logic [PREG_W-1:0]       crat      [ARCH_REGS];
    logic [PREG_W-1:0]       crat_next [ARCH_REGS];
    logic [WIDTH-1:0]        wr;
    logic [WIDTH-1:0]        waw;
    logic [POP_W-1:0]        need;
    logic [WIDTH*PREG_W-1:0] pdst_new;
    logic [WIDTH*PREG_W-1:0] psrc1;
    logic [WIDTH*PREG_W-1:0] psrc2;
    logic [WIDTH*PREG_W-1:0] pdst_old;
    logic                    accept;

    function automatic logic [AREG_W-1:0] areg(input logic [WIDTH*AREG_W-1:0] v, input int k);
        return v[k*AREG_W +: AREG_W];
    endfunction

    always_comb begin
        wr   = bus.in_dst_valid;
`ifdef RENAME_X0_ZERO_EN
        for (int k = 0; k < WIDTH; k++) begin
            if (areg(bus.in_rd, k) == '0) wr[k] = 1'b0;
        end
`endif
        need = '0;
        for (int k = 0; k < WIDTH; k++) need = need + POP_W'(wr[k]);
    end

    // The j-th writing slot takes the j-th free-list head entry.
    always_comb begin
        int j;
        j        = 0;
        pdst_new = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (wr[k]) begin
                pdst_new[k*PREG_W +: PREG_W] = bus.fl_preg[j*PREG_W +: PREG_W];
                j = j + 1;
            end
        end
    end

    // Ascending scan of older slots leaves the youngest matching writer in place.
    always_comb begin
        psrc1    = '0;
        psrc2    = '0;
        pdst_old = '0;
        waw      = '0;
        for (int k = 0; k < WIDTH; k++) begin
            psrc1[k*PREG_W +: PREG_W] = srat[areg(bus.in_rs1, k)];
            psrc2[k*PREG_W +: PREG_W] = srat[areg(bus.in_rs2, k)];
            if (wr[k]) pdst_old[k*PREG_W +: PREG_W] = srat[areg(bus.in_rd, k)];
            for (int i = 0; i < k; i++) begin
                if (wr[i] && bus.in_uses_rs1[k] && areg(bus.in_rd, i) == areg(bus.in_rs1, k))
                    psrc1[k*PREG_W +: PREG_W] = pdst_new[i*PREG_W +: PREG_W];
                if (wr[i] && bus.in_uses_rs2[k] && areg(bus.in_rd, i) == areg(bus.in_rs2, k))
                    psrc2[k*PREG_W +: PREG_W] = pdst_new[i*PREG_W +: PREG_W];
                if (wr[i] && wr[k] && areg(bus.in_rd, i) == areg(bus.in_rd, k))
                    pdst_old[k*PREG_W +: PREG_W] = pdst_new[i*PREG_W +: PREG_W];
            end
            for (int i = k + 1; i < WIDTH; i++) begin
                if (wr[i] && wr[k] && areg(bus.in_rd, i) == areg(bus.in_rd, k)) waw[k] = 1'b1;
            end
`ifdef RENAME_X0_ZERO_EN
            if (areg(bus.in_rs1, k) == '0) psrc1[k*PREG_W +: PREG_W] = '0;
            if (areg(bus.in_rs2, k) == '0) psrc2[k*PREG_W +: PREG_W] = '0;
`endif
        end
    end

    always_comb begin
        crat_next = crat;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.commit_valid[k])
                crat_next[areg(bus.commit_rd, k)] = bus.commit_preg[k*PREG_W +: PREG_W];
        end
`ifdef RENAME_X0_ZERO_EN
        crat_next[0] = '0;
`endif
    end

    assign bus.in_ready = !bus.flush && (!bus.out_valid || bus.out_ready) &&
                          (bus.fl_count >= CNT_W'(need));
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.fl_pop   = accept ? need : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                srat[i] <= PREG_W'(i);
                crat[i] <= PREG_W'(i);
            end
        end else begin
            crat <= crat_next;
            if (bus.flush) begin
                srat <= crat_next;
            end else if (accept) begin
                for (int k = 0; k < WIDTH; k++) begin
                    if (wr[k] && !waw[k])
                        srat[areg(bus.in_rd, k)] <= pdst_new[k*PREG_W +: PREG_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_valid     <= 1'b0;
            bus.out_dst_valid <= '0;
            bus.out_psrc1     <= '0;
            bus.out_psrc2     <= '0;
            bus.out_pdst      <= '0;
            bus.out_pdst_old  <= '0;
            bus.out_waw       <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid     <= 1'b1;
            bus.out_dst_valid <= wr;
            bus.out_psrc1     <= psrc1;
            bus.out_psrc2     <= psrc2;
            bus.out_pdst      <= pdst_new;
            bus.out_pdst_old  <= pdst_old;
            bus.out_waw       <= waw;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
